// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_reg_if
//  Brief    : Bundle between the decode stage (master) and the ID/EX pipeline
//             register (slave). Carries the decoded instruction fields, the
//             pipeline control requests and the registered copies.
//             The optional bubble counter is present only when IDEX_PERF_EN
//             is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
`ifdef IDEX_PERF_EN
  ,
  parameter int PERF_CNT_W = 16
`endif
);

  // Pipeline control requests
  logic               Hold_i;
  logic               Flush_i;
  logic               Stall_i;

  // Decoded instruction entering the stage
  logic               RegWrite_i;
  logic               MemtoReg_i;
  logic               MemRead_i;
  logic               MemWrite_i;
  logic               Branch_i;
  logic               ALUSrc_i;
  logic [1:0]         ALUOp_i;
  logic [DATA_W-1:0]  RS1data_i;
  logic [DATA_W-1:0]  RS2data_i;
  logic [DATA_W-1:0]  Imm_i;
  logic [DATA_W-1:0]  PC_i;
  logic [9:0]         funct_i;
  logic [RADDR_W-1:0] RS1addr_i;
  logic [RADDR_W-1:0] RS2addr_i;
  logic [RADDR_W-1:0] RDaddr_i;

  // Registered copies presented to EX
  logic               RegWrite_o;
  logic               MemtoReg_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               Branch_o;
  logic               ALUSrc_o;
  logic [1:0]         ALUOp_o;
  logic [DATA_W-1:0]  RS1data_o;
  logic [DATA_W-1:0]  RS2data_o;
  logic [DATA_W-1:0]  Imm_o;
  logic [DATA_W-1:0]  PC_o;
  logic [9:0]         funct_o;
  logic [RADDR_W-1:0] RS1addr_o;
  logic [RADDR_W-1:0] RS2addr_o;
  logic [RADDR_W-1:0] RDaddr_o;
  logic               Valid_o;
`ifdef IDEX_PERF_EN
  logic [PERF_CNT_W-1:0] BubbleCnt_o;
`endif

  // Decode side: drives the instruction and the control requests
  modport master (
    output Hold_i, Flush_i, Stall_i,
    output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
    output ALUOp_i, RS1data_i, RS2data_i, Imm_i, PC_i, funct_i,
    output RS1addr_i, RS2addr_i, RDaddr_i,
`ifdef IDEX_PERF_EN
    input  BubbleCnt_o,
`endif
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o,
    input  ALUOp_o, RS1data_o, RS2data_o, Imm_o, PC_o, funct_o,
    input  RS1addr_o, RS2addr_o, RDaddr_o, Valid_o
  );

  // Pipeline register side
  modport slave (
    input  Hold_i, Flush_i, Stall_i,
    input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i, ALUSrc_i,
    input  ALUOp_i, RS1data_i, RS2data_i, Imm_i, PC_i, funct_i,
    input  RS1addr_i, RS2addr_i, RDaddr_i,
`ifdef IDEX_PERF_EN
    output BubbleCnt_o,
`endif
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o,
    output ALUOp_o, RS1data_o, RS2data_o, Imm_o, PC_o, funct_o,
    output RS1addr_o, RS2addr_o, RDaddr_o, Valid_o
  );

endinterface : id_ex_stage_reg_if
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage_reg
//  Brief    : ID/EX pipeline register. Captures the decoded control bundle,
//             operands, immediate, funct bits, register addresses and PC once
//             per cycle, and implements freeze (hold), squash (flush) and
//             load-use bubble (stall). A Valid bit marks real instructions.
//             Edge priority: reset > hold > flush/stall > load.
//             Optional: IDEX_PERF_EN adds a saturating bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
`ifdef IDEX_PERF_EN
  ,
  parameter int PERF_CNT_W = 16
`endif
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  id_ex_stage_reg_if.slave bus
);

  localparam int c_funct_w = 10;

  // Slot state: VALID holds a real instruction, BUBBLE holds a no-op
  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic   w_load;
  logic   w_bubble;

  // Registered payload
  logic                 r_regwrite;
  logic                 r_memtoreg;
  logic                 r_memread;
  logic                 r_memwrite;
  logic                 r_branch;
  logic                 r_alusrc;
  logic [1:0]           r_aluop;
  logic [DATA_W-1:0]    r_rs1data;
  logic [DATA_W-1:0]    r_rs2data;
  logic [DATA_W-1:0]    r_imm;
  logic [DATA_W-1:0]    r_pc;
  logic [c_funct_w-1:0] r_funct;
  logic [RADDR_W-1:0]   r_rs1addr;
  logic [RADDR_W-1:0]   r_rs2addr;
  logic [RADDR_W-1:0]   r_rdaddr;

  // Decide this edge's action and the next slot state; hold wins over any bubble request
  always_comb begin
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_state_nxt = r_state;
    if (!bus.Hold_i) begin
      if (bus.Flush_i || bus.Stall_i) begin
        w_bubble    = 1'b1;
        w_state_nxt = ST_BUBBLE;
      end else begin
        w_load      = 1'b1;
        w_state_nxt = ST_VALID;
      end
    end
  end

  // Slot state register; reset leaves the slot empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_BUBBLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload register: a bubble clears every field so forwarding never matches it
  always_ff @(posedge clk_i) begin
    if (rst_i || w_bubble) begin
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluop    <= 2'b00;
      r_rs1data  <= '0;
      r_rs2data  <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_funct    <= '0;
      r_rs1addr  <= '0;
      r_rs2addr  <= '0;
      r_rdaddr   <= '0;
    end else if (w_load) begin
      r_regwrite <= bus.RegWrite_i;
      r_memtoreg <= bus.MemtoReg_i;
      r_memread  <= bus.MemRead_i;
      r_memwrite <= bus.MemWrite_i;
      r_branch   <= bus.Branch_i;
      r_alusrc   <= bus.ALUSrc_i;
      r_aluop    <= bus.ALUOp_i;
      r_rs1data  <= bus.RS1data_i;
      r_rs2data  <= bus.RS2data_i;
      r_imm      <= bus.Imm_i;
      r_pc       <= bus.PC_i;
      r_funct    <= bus.funct_i;
      r_rs1addr  <= bus.RS1addr_i;
      r_rs2addr  <= bus.RS2addr_i;
      r_rdaddr   <= bus.RDaddr_i;
    end
  end

`ifdef IDEX_PERF_EN
  localparam logic [PERF_CNT_W-1:0] c_cnt_max = {PERF_CNT_W{1'b1}};

  logic [PERF_CNT_W-1:0] r_bubble_cnt;

  // Count inserted bubbles, saturating instead of wrapping; flush+stall counts once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bus.BubbleCnt_o = r_bubble_cnt;
`endif

  // Outputs come straight from registers: no input-to-output combinational path
  assign bus.RegWrite_o = r_regwrite;
  assign bus.MemtoReg_o = r_memtoreg;
  assign bus.MemRead_o  = r_memread;
  assign bus.MemWrite_o = r_memwrite;
  assign bus.Branch_o   = r_branch;
  assign bus.ALUSrc_o   = r_alusrc;
  assign bus.ALUOp_o    = r_aluop;
  assign bus.RS1data_o  = r_rs1data;
  assign bus.RS2data_o  = r_rs2data;
  assign bus.Imm_o      = r_imm;
  assign bus.PC_o       = r_pc;
  assign bus.funct_o    = r_funct;
  assign bus.RS1addr_o  = r_rs1addr;
  assign bus.RS2addr_o  = r_rs2addr;
  assign bus.RDaddr_o   = r_rdaddr;
  assign bus.Valid_o    = (r_state == ST_VALID);

  // A bubble must never carry side-effecting control into EX/MEM/WB
  a_bubble_is_inert : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (r_state == ST_BUBBLE) |-> !(r_regwrite || r_memread || r_memwrite || r_branch)
  );

endmodule : id_ex_stage_reg
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage_reg
//  Brief    : Self-checking bench for id_ex_stage_reg. A behavioural model
//             tracks what the stage must hold from the reset/hold/bubble/load
//             rules; a compare process checks every cycle. Directed scenarios
//             pin the model with literal values. Counter checks apply when
//             IDEX_PERF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage_reg;

  localparam int DATA_W     = 32;
  localparam int RADDR_W    = 5;
  localparam int PERF_CNT_W = 2;
  localparam int CNT_MAX    = (1 << PERF_CNT_W) - 1;

  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               alusrc;
    logic [1:0]         aluop;
    logic [DATA_W-1:0]  rs1data;
    logic [DATA_W-1:0]  rs2data;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
    logic [9:0]         funct;
    logic [RADDR_W-1:0] rs1addr;
    logic [RADDR_W-1:0] rs2addr;
    logic [RADDR_W-1:0] rdaddr;
  } bundle_t;

  logic    clk;
  logic    rst, hold, flush, stall;
  bundle_t drv, got, exp_b, saved;
  logic    exp_v;
  int      bubbles;
  bit      started;
  int      checks, errors;

`ifdef IDEX_PERF_EN
  id_ex_stage_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PERF_CNT_W(PERF_CNT_W)) bus ();
  id_ex_stage_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .PERF_CNT_W(PERF_CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));
`else
  id_ex_stage_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) bus ();
  id_ex_stage_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));
`endif

  assign bus.Hold_i     = hold;
  assign bus.Flush_i    = flush;
  assign bus.Stall_i    = stall;
  assign bus.RegWrite_i = drv.regwrite;
  assign bus.MemtoReg_i = drv.memtoreg;
  assign bus.MemRead_i  = drv.memread;
  assign bus.MemWrite_i = drv.memwrite;
  assign bus.Branch_i   = drv.branch;
  assign bus.ALUSrc_i   = drv.alusrc;
  assign bus.ALUOp_i    = drv.aluop;
  assign bus.RS1data_i  = drv.rs1data;
  assign bus.RS2data_i  = drv.rs2data;
  assign bus.Imm_i      = drv.imm;
  assign bus.PC_i       = drv.pc;
  assign bus.funct_i    = drv.funct;
  assign bus.RS1addr_i  = drv.rs1addr;
  assign bus.RS2addr_i  = drv.rs2addr;
  assign bus.RDaddr_i   = drv.rdaddr;

  assign got = '{regwrite: bus.RegWrite_o, memtoreg: bus.MemtoReg_o, memread: bus.MemRead_o,
                 memwrite: bus.MemWrite_o, branch: bus.Branch_o, alusrc: bus.ALUSrc_o,
                 aluop: bus.ALUOp_o, rs1data: bus.RS1data_o, rs2data: bus.RS2data_o,
                 imm: bus.Imm_o, pc: bus.PC_o, funct: bus.funct_o, rs1addr: bus.RS1addr_o,
                 rs2addr: bus.RS2addr_o, rdaddr: bus.RDaddr_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.regwrite = 1'($urandom_range(0, 1));
    b.memtoreg = 1'($urandom_range(0, 1));
    b.memread  = 1'($urandom_range(0, 1));
    b.memwrite = 1'($urandom_range(0, 1));
    b.branch   = 1'($urandom_range(0, 1));
    b.alusrc   = 1'($urandom_range(0, 1));
    b.aluop    = 2'($urandom_range(0, 3));
    b.rs1data  = $urandom;
    b.rs2data  = $urandom;
    b.imm      = $urandom;
    b.pc       = $urandom;
    b.funct    = 10'($urandom);
    b.rs1addr  = 5'($urandom);
    b.rs2addr  = 5'($urandom);
    b.rdaddr   = 5'($urandom);
    return b;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: what the slot must contain after each edge
  always @(posedge clk) begin
    if (rst) begin
      exp_b   = '0;
      exp_v   = 1'b0;
      bubbles = 0;
    end else if (hold) begin
      // frozen
    end else if (flush || stall) begin
      exp_b   = '0;
      exp_v   = 1'b0;
      bubbles = bubbles + 1;
    end else begin
      exp_b = drv;
      exp_v = 1'b1;
    end
    started = 1'b1;
  end

  // Cycle-by-cycle comparison against the reference
  always @(negedge clk) begin
    if (started) begin
      chk("model_payload", 256'(got), 256'(exp_b));
      chk("model_valid", 256'(bus.Valid_o), 256'(exp_v));
      if (!bus.Valid_o)
        chk("bubble_inert", 256'({bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.Branch_o}), 256'(0));
`ifdef IDEX_PERF_EN
      chk("model_bubblecnt", 256'(bus.BubbleCnt_o), 256'((bubbles > CNT_MAX) ? CNT_MAX : bubbles));
`endif
    end
  end

  initial begin
    checks = 0; errors = 0; started = 1'b0; bubbles = 0;
    exp_b = '0; exp_v = 1'b0; saved = '0;
    rst = 1'b1; hold = 1'b0; flush = 1'b0; stall = 1'b0;

    // Reset for two cycles with random inputs
    drv = rand_bundle();
    cyc();
    drv = rand_bundle(); hold = 1'($urandom_range(0, 1));
    cyc();
    chk("reset_valid", 256'(bus.Valid_o), 256'(0));
    chk("reset_payload", 256'(got), 256'(0));
    chk("reset_aluop", 256'(bus.ALUOp_o), 256'(0));
    rst = 1'b0; hold = 1'b0;

    // Plain load
    drv = '0; drv.rs1data = 32'h1234_5678; drv.rdaddr = 5'd7; drv.regwrite = 1'b1; drv.aluop = 2'b10;
    cyc();
    chk("load_rs1data", 256'(bus.RS1data_o), 256'(32'h1234_5678));
    chk("load_rdaddr", 256'(bus.RDaddr_o), 256'(7));
    chk("load_regwrite", 256'(bus.RegWrite_o), 256'(1));
    chk("load_aluop", 256'(bus.ALUOp_o), 256'(2));
    chk("load_valid", 256'(bus.Valid_o), 256'(1));

    // Load-use: LW then one stall cycle
    drv = '0; drv.memread = 1'b1; drv.rdaddr = 5'd5;
    cyc();
    chk("lw_memread", 256'(bus.MemRead_o), 256'(1));
    chk("lw_rdaddr", 256'(bus.RDaddr_o), 256'(5));
    chk("lw_valid", 256'(bus.Valid_o), 256'(1));
    stall = 1'b1;
    cyc();
    stall = 1'b0;
    chk("stall_rdaddr", 256'(bus.RDaddr_o), 256'(0));
    chk("stall_memread", 256'(bus.MemRead_o), 256'(0));
    chk("stall_valid", 256'(bus.Valid_o), 256'(0));

    // Hold beats flush for three cycles, then flush takes effect
    drv = rand_bundle(); saved = drv;
    cyc();
    hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv = rand_bundle();
      cyc();
      chk("hold_frozen", 256'(got), 256'(saved));
      chk("hold_valid", 256'(bus.Valid_o), 256'(1));
    end
    hold = 1'b0;
    cyc();
    flush = 1'b0;
    chk("flush_payload", 256'(got), 256'(0));
    chk("flush_valid", 256'(bus.Valid_o), 256'(0));

    // Reset while held
    drv = rand_bundle();
    cyc();
    hold = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0; hold = 1'b0;
    chk("midhold_rst_payload", 256'(got), 256'(0));
    chk("midhold_rst_valid", 256'(bus.Valid_o), 256'(0));

`ifdef IDEX_PERF_EN
    // Saturating counter: flush+stall together count once
    rst = 1'b1; cyc(); rst = 1'b0;
    flush = 1'b1; stall = 1'b1; cyc(); chk("cnt_1", 256'(bus.BubbleCnt_o), 256'(1));
    flush = 1'b1; stall = 1'b0; cyc(); chk("cnt_2", 256'(bus.BubbleCnt_o), 256'(2));
    flush = 1'b0; stall = 1'b1; cyc(); chk("cnt_3", 256'(bus.BubbleCnt_o), 256'(3));
    flush = 1'b1; stall = 1'b0; cyc(); chk("cnt_sat_a", 256'(bus.BubbleCnt_o), 256'(3));
    flush = 1'b0; stall = 1'b1; cyc(); chk("cnt_sat_b", 256'(bus.BubbleCnt_o), 256'(3));
    stall = 1'b0;
    hold = 1'b1; flush = 1'b1; cyc(); chk("cnt_hold", 256'(bus.BubbleCnt_o), 256'(3));
    hold = 1'b0; flush = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("cnt_rst", 256'(bus.BubbleCnt_o), 256'(0));
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 99) < 2);
      hold  = ($urandom_range(0, 99) < 15);
      flush = ($urandom_range(0, 99) < 12);
      stall = ($urandom_range(0, 99) < 12);
      drv   = rand_bundle();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_stage_reg
`default_nettype wire
